tick_counter_bank: RTL

TICK_COUNTER_BANK -- requirements
Module: tick_counter_bank

---
 rtl/tick_counter_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tick_counter_bank.sv
// -----------------------------------------------------------------------------
// tick_counter_bank
//
// Bank of CHANNELS independent up-counters sharing one terminal value.
// Each channel clears, loads, counts or holds, in that priority order, every
// clock. A channel that reaches the shared limit either sticks there
// (WRAP_MODE = 0) or returns to zero with a one-cycle wrap pulse
// (WRAP_MODE = 1).
//
// Optional feature (macro TICK_COUNTER_BANK_WRAPCNT_EN):
//   adds output wrap_cnt, an 8-bit saturating wrap-event count per channel.
//   With the macro undefined the port and its logic are absent.
//
// Parameters
//   CHANNELS    number of independent counters
//   COUNT_BITS  width of each counter
//   WRAP_MODE   0 = saturate at limit, 1 = wrap to zero after limit
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   synchronous active-high reset
//   en            in   [CHANNELS]            per-channel count enable
//   clear         in   [CHANNELS]            per-channel clear to zero
//   load          in   [CHANNELS]            per-channel load strobe
//   load_val      in   [CHANNELS*COUNT_BITS] load values, channel i at [i*COUNT_BITS +: COUNT_BITS]
//   limit         in   [COUNT_BITS]          shared terminal value
//   count         out  [CHANNELS*COUNT_BITS] registered counter values
//   at_limit      out  [CHANNELS]            combinational count[i] >= limit
//   wrap_pulse    out  [CHANNELS]            registered one-cycle wrap pulse
//   all_at_limit  out  1                     AND of at_limit
//   wrap_cnt      out  [CHANNELS*8]          wrap event counts (macro only)
// -----------------------------------------------------------------------------
module tick_counter_bank #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_BITS = 8,
    parameter int WRAP_MODE  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            en,
    input  logic [CHANNELS-1:0]            clear,
    input  logic [CHANNELS-1:0]            load,
    input  logic [CHANNELS*COUNT_BITS-1:0] load_val,
    input  logic [COUNT_BITS-1:0]          limit,
    output logic [CHANNELS*COUNT_BITS-1:0] count,
    output logic [CHANNELS-1:0]            at_limit,
    output logic [CHANNELS-1:0]            wrap_pulse,
    output logic                           all_at_limit
`ifdef TICK_COUNTER_BANK_WRAPCNT_EN
    ,
    output logic [CHANNELS*8-1:0]          wrap_cnt
`endif
);

    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    logic [CHANNELS-1:0][COUNT_BITS-1:0] count_q;
    logic [CHANNELS-1:0][COUNT_BITS-1:0] count_d;
    logic [CHANNELS-1:0][COUNT_BITS-1:0] load_val_s;
    logic [CHANNELS-1:0]                 wrap_pulse_q;
    logic [CHANNELS-1:0]                 wrap_pulse_d;
    logic [CHANNELS-1:0]                 at_limit_s;

`ifdef TICK_COUNTER_BANK_WRAPCNT_EN
    logic [CHANNELS-1:0][7:0]            wrap_cnt_q;
    logic [CHANNELS-1:0][7:0]            wrap_cnt_d;
`endif

    assign load_val_s = load_val;

    // Per-channel limit compare; ">=" (not "==") so a limit lowered below the
    // current count still counts as reached and no roll-over past the top occurs.
    always_comb begin
        at_limit_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (count_q[i] >= limit) begin
                at_limit_s[i] = 1'b1;
            end else begin
                at_limit_s[i] = 1'b0;
            end
        end
    end

    // Next-state per channel: clear > load > en > hold (reset handled in the flop).
    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = '0;
`ifdef TICK_COUNTER_BANK_WRAPCNT_EN
        wrap_cnt_d   = wrap_cnt_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
                count_d[i] = '0;
`ifdef TICK_COUNTER_BANK_WRAPCNT_EN
                wrap_cnt_d[i] = 8'd0;
`endif
            end else if (load[i]) begin
                // Loads are clamped to the limit and never raise a wrap pulse.
                if (load_val_s[i] > limit) begin
                    count_d[i] = limit;
                end else begin
                    count_d[i] = load_val_s[i];
                end
            end else if (en[i]) begin
                if (!at_limit_s[i]) begin
                    count_d[i] = count_q[i] + CNT_ONE;
                end else if (WRAP_MODE != 0) begin
                    count_d[i]      = '0;
                    wrap_pulse_d[i] = 1'b1;
`ifdef TICK_COUNTER_BANK_WRAPCNT_EN
                    if (wrap_cnt_q[i] == 8'd255) begin
                        wrap_cnt_d[i] = 8'd255;
                    end else begin
                        wrap_cnt_d[i] = wrap_cnt_q[i] + 8'd1;
                    end
`endif
                end else begin
                    count_d[i] = count_q[i];
                end
            end else begin
                count_d[i] = count_q[i];
            end
        end
    end

    // Counter and wrap-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            wrap_pulse_q <= '0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

`ifdef TICK_COUNTER_BANK_WRAPCNT_EN
    // Wrap event counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

    assign count        = count_q;
    assign wrap_pulse   = wrap_pulse_q;
    assign at_limit     = at_limit_s;
    assign all_at_limit = &at_limit_s;

endmodule
